// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg -- shared types and constants for the reset sequencer.
//   rst_seq_state_e : FSM state encoding (also exported on state_o).
//   LockLossCntW    : width of the saturating lock-loss counter.
//   Def*            : default parameter values for rst_sequencer.
//   cnt_w()         : counter width helper, $clog2 of terminal value, min 1.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      ST_HOLD     = 3'd0,
      ST_DEBOUNCE = 3'd1,
      ST_RELEASE  = 3'd2,
      ST_RUN      = 3'd3,
      ST_SW_HOLD  = 3'd4
   } rst_seq_state_e;

   localparam int LockLossCntW     = 8;

   localparam int DefNumDomains    = 3;
   localparam int DefLockDebounce  = 256;
   localparam int DefStageGap      = 16;
   localparam int DefSwRstHold     = 32;
   localparam int DefLockTimeout   = 65536;

   function automatic int cnt_w(input int terminal);
      return (terminal > 1) ? $clog2(terminal) : 1;
   endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// rst_seq_sync -- generic 2-flop synchroniser.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, clears both stages to 0
//   d_i   : asynchronous input, Width bits
//   q_o   : synchronised output, Width bits
module rst_seq_sync #(
   parameter int Width = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer -- debounced, staggered per-domain reset release after PLL lock.
//   clk_i           : main clock
//   rst_i           : synchronous active-high reset
//   locked_i        : PLL/MMCM lock, asynchronous to clk_i
//   sw_rst_req_i    : single-cycle software reset request
//   rst_no          : per-domain active-low resets, registered
//   all_released_o  : every domain out of reset
//   state_o         : FSM state, debug
//   lock_loss_cnt_o : saturating count of lock losses after first release
//   lock_timeout_o  : sticky lock timeout flag
// Optional: define RST_SEQ_WDOG_EN to build the DEBOUNCE watchdog timer
// (parameter LockTimeout); otherwise lock_timeout_o is tied to 0.
module rst_sequencer
   import rst_seq_pkg::*;
#(
   parameter int NumDomains   = DefNumDomains,
   parameter int LockDebounce = DefLockDebounce,
   parameter int StageGap     = DefStageGap,
   parameter int SwRstHold    = DefSwRstHold
`ifdef RST_SEQ_WDOG_EN
   ,
   parameter int LockTimeout  = DefLockTimeout
`endif
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    locked_i,
   input  logic                    sw_rst_req_i,
   output logic [NumDomains-1:0]   rst_no,
   output logic                    all_released_o,
   output logic [2:0]              state_o,
   output logic [LockLossCntW-1:0] lock_loss_cnt_o,
   output logic                    lock_timeout_o
);

   localparam int DebW  = cnt_w(LockDebounce);
   localparam int GapW  = cnt_w(StageGap);
   localparam int IdxW  = cnt_w(NumDomains);
   localparam int HoldW = cnt_w(SwRstHold);

   localparam logic [DebW-1:0]  DebLast  = DebW'(LockDebounce - 1);
   localparam logic [GapW-1:0]  GapLast  = GapW'(StageGap - 1);
   localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NumDomains - 1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(SwRstHold - 1);

   logic lock_q;

   rst_seq_sync #(.Width(1)) u_lock_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (locked_i),
      .q_o   (lock_q)
   );

   rst_seq_state_e           state_q, state_d;
   logic [DebW-1:0]          deb_q,   deb_d;
   logic [GapW-1:0]          gap_q,   gap_d;
   logic [IdxW-1:0]          idx_q,   idx_d;
   logic [HoldW-1:0]         hold_q,  hold_d;
   logic [NumDomains-1:0]    rst_n_q, rst_n_d;
   logic                     rel_q,   rel_d;
   logic [LockLossCntW-1:0]  loss_q,  loss_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_HOLD;
         deb_q   <= '0;
         gap_q   <= '0;
         idx_q   <= '0;
         hold_q  <= '0;
         rst_n_q <= '0;
         rel_q   <= 1'b0;
         loss_q  <= '0;
      end else begin
         state_q <= state_d;
         deb_q   <= deb_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         rst_n_q <= rst_n_d;
         rel_q   <= rel_d;
         loss_q  <= loss_d;
      end
   end

   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      gap_d   = gap_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      rst_n_d = rst_n_q;
      rel_d   = rel_q;
      loss_d  = loss_q;

      unique case (state_q)
         ST_HOLD: begin
            state_d = ST_DEBOUNCE;
            deb_d   = '0;
         end

         ST_DEBOUNCE: begin
            if (!lock_q) begin
               deb_d = '0;
            end else if (deb_q == DebLast) begin
               state_d = ST_RELEASE;
               deb_d   = '0;
               idx_d   = '0;
               gap_d   = '0;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end

         ST_RELEASE, ST_RUN, ST_SW_HOLD: begin
            if (!lock_q) begin
               // lock loss wins over a simultaneous software request
               state_d = ST_DEBOUNCE;
               deb_d   = '0;
               rst_n_d = '0;
               rel_d   = 1'b0;
               if (loss_q != '1) loss_d = loss_q + 1'b1;
            end else if (sw_rst_req_i && state_q != ST_SW_HOLD) begin
               state_d = ST_SW_HOLD;
               hold_d  = '0;
               rst_n_d = '0;
               rel_d   = 1'b0;
            end else if (state_q == ST_RELEASE) begin
               if (gap_q == GapLast) begin
                  gap_d   = '0;
                  // releasing by OR keeps lower domains released
                  rst_n_d = rst_n_q | (NumDomains'(1) << idx_q);
                  if (idx_q == IdxLast) begin
                     state_d = ST_RUN;
                     rel_d   = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end else if (state_q == ST_SW_HOLD) begin
               if (hold_q == HoldLast) begin
                  state_d = ST_RELEASE;
                  hold_d  = '0;
                  idx_d   = '0;
                  gap_d   = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_HOLD;
            rst_n_d = '0;
            rel_d   = 1'b0;
         end
      endcase
   end

   assign rst_no          = rst_n_q;
   assign all_released_o  = rel_q;
   assign state_o         = state_q;
   assign lock_loss_cnt_o = loss_q;

`ifdef RST_SEQ_WDOG_EN
   localparam int WdogW = cnt_w(LockTimeout);
   localparam logic [WdogW-1:0] WdogLast = WdogW'(LockTimeout - 1);

   logic [WdogW-1:0] wdog_q;
   logic             tout_q;

   // Timer stops at its terminal value rather than wrapping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wdog_q <= '0;
         tout_q <= 1'b0;
      end else if (state_q == ST_DEBOUNCE) begin
         if (wdog_q == WdogLast) tout_q <= 1'b1;
         else                    wdog_q <= wdog_q + 1'b1;
      end else begin
         wdog_q <= '0;
      end
   end

   assign lock_timeout_o = tout_q;
`else
   assign lock_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer -- directed bench for rst_sequencer with
// NumDomains=3, LockDebounce=4, StageGap=2, SwRstHold=3 (LockTimeout=10
// when RST_SEQ_WDOG_EN is defined). Inputs change and outputs are sampled
// 1 time unit after a rising edge; "edge N" comments count rising edges.
module tb_rst_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       locked = 1'b0;
   logic       sw = 1'b0;
   logic [2:0] rst_n;
   logic       all_rel;
   logic [2:0] state;
   logic [7:0] loss_cnt;
   logic       tout;

   int checks   = 0;
   int failures = 0;
   int exp_cnt;

`ifdef RST_SEQ_WDOG_EN
   localparam logic WdExp = 1'b1;
`else
   localparam logic WdExp = 1'b0;
`endif

   rst_sequencer #(
      .NumDomains   (3),
      .LockDebounce (4),
      .StageGap     (2),
      .SwRstHold    (3)
`ifdef RST_SEQ_WDOG_EN
      ,
      .LockTimeout  (10)
`endif
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .locked_i        (locked),
      .sw_rst_req_i    (sw),
      .rst_no          (rst_n),
      .all_released_o  (all_rel),
      .state_o         (state),
      .lock_loss_cnt_o (loss_cnt),
      .lock_timeout_o  (tout)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // ---- power-up: reset held for edges 1..5
      tick(5);
      chk("rst_rst_no",   rst_n,    0);
      chk("rst_all_rel",  all_rel,  0);
      chk("rst_state",    state,    0);
      chk("rst_loss_cnt", loss_cnt, 0);
      chk("rst_tout",     tout,     0);
      rst = 1'b0;
      tick(1);                               // edge 6: HOLD -> DEBOUNCE
      chk("pu_debounce", state, 1);
      tick(4);                               // edge 10
      locked = 1'b1;
      tick(7);                               // edge 17
      chk("pu_17_rst_no", rst_n, 3'b000);
      tick(1);                               // edge 18
      chk("pu_18_rst_no", rst_n, 3'b001);
      chk("pu_18_state",  state, 2);
      tick(1);
      chk("pu_19_rst_no", rst_n, 3'b001);
      tick(1);                               // edge 20
      chk("pu_20_rst_no", rst_n, 3'b011);
      chk("pu_20_all_rel", all_rel, 0);
      tick(2);                               // edge 22
      chk("pu_22_rst_no", rst_n, 3'b111);
      chk("pu_22_all_rel", all_rel, 1);
      chk("pu_22_state", state, 3);

      // ---- lock glitch during DEBOUNCE, from a fresh reset
      rst = 1'b1; locked = 1'b0;
      tick(2);
      chk("gl_rst_no", rst_n, 3'b000);
      rst = 1'b0;
      tick(1);
      chk("gl_debounce", state, 1);
      tick(2);
      locked = 1'b1;                         // edge a
      tick(3);
      locked = 1'b0;                         // edge a+3
      tick(1);
      locked = 1'b1;                         // edge a+4: second rise
      tick(7);                               // a+11
      chk("gl_a11_rst_no", rst_n, 3'b000);
      tick(1);                               // a+12 = second rise + 8
      chk("gl_a12_rst_no", rst_n, 3'b001);
      chk("gl_loss_cnt", loss_cnt, 0);
      tick(4);
      chk("gl_run_rst_no", rst_n, 3'b111);
      chk("gl_run_state", state, 3);

      // ---- lock loss in RUN
      locked = 1'b0;                         // edge c
      tick(2);
      chk("ll_c2_rst_no", rst_n, 3'b111);
      tick(1);                               // c+3
      chk("ll_rst_no",   rst_n,    3'b000);
      chk("ll_all_rel",  all_rel,  0);
      chk("ll_state",    state,    1);
      chk("ll_loss_cnt", loss_cnt, 1);
      locked = 1'b1;
      tick(7);
      chk("ll_re_7", rst_n, 3'b000);
      tick(1);
      chk("ll_re_8", rst_n, 3'b001);
      tick(2);
      chk("ll_re_10", rst_n, 3'b011);
      tick(2);
      chk("ll_re_12", rst_n, 3'b111);
      chk("ll_re_state", state, 3);

      // ---- software reset in RUN
      sw = 1'b1;                             // edge k
      tick(1);
      sw = 1'b0;                             // k+1
      chk("sw_rst_no",  rst_n,   3'b000);
      chk("sw_state",   state,   4);
      chk("sw_all_rel", all_rel, 0);
      tick(2);                               // k+3
      chk("sw_k3_state", state, 4);
      tick(1);                               // k+4
      chk("sw_k4_state", state, 2);
      tick(1);
      chk("sw_k5_rst_no", rst_n, 3'b000);
      tick(1);                               // k+6
      chk("sw_k6_rst_no", rst_n, 3'b001);
      chk("sw_loss_cnt", loss_cnt, 1);
      tick(4);
      chk("sw_run_rst_no", rst_n, 3'b111);

      // ---- software request ignored in DEBOUNCE (lock low)
      locked = 1'b0;
      tick(3);
      chk("ig_state", state, 1);
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      chk("ig_sw_state", state, 1);
      chk("ig_loss_cnt", loss_cnt, 2);

      // ---- collision: request in the cycle lock_q falls
      locked = 1'b1;
      tick(12);
      chk("co_run", state, 3);
      locked = 1'b0;                         // edge k
      tick(2);
      sw = 1'b1;                             // lock_q now 0
      tick(1);                               // k+3
      sw = 1'b0;
      chk("co_state",    state,    1);
      chk("co_rst_no",   rst_n,    3'b000);
      chk("co_loss_cnt", loss_cnt, 3);

      // ---- saturation of the lock-loss counter
      exp_cnt = 3;
      for (int i = 0; i < 256; i++) begin
         locked = 1'b1;
         tick(9);                            // domain 0 released, in RELEASE
         locked = 1'b0;
         tick(3);
         if (exp_cnt < 255) exp_cnt++;
         if (i == 10) chk("sat_mid", loss_cnt, exp_cnt);
      end
      chk("sat_state",    state,    1);
      chk("sat_loss_cnt", loss_cnt, 255);

      // ---- watchdog: lock held low in DEBOUNCE
      rst = 1'b1; locked = 1'b0;
      tick(2);
      rst = 1'b0;                            // edge e
      tick(10);                              // e+10: 9 cycles in DEBOUNCE
      chk("wd_e10", tout, 0);
      tick(1);                               // e+11
      chk("wd_e11", tout, WdExp);
      locked = 1'b1;
      tick(14);
      chk("wd_run_state", state, 3);
      chk("wd_sticky", tout, WdExp);
      rst = 1'b1;
      tick(1);
      chk("wd_cleared", tout, 0);
      chk("wd_rst_state", state, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
